hf_xfer_sched: RTL

Transaction scheduler that shares the hyperfabric block mover and its MCU DRAM port among four section requesters (sections 0-3).
- Round-robin arbitration between sections.
- Latches the winner's descriptor and drives the MCU alignment request/grant handshake.
- Issues the block-mover start and tracks BLCK_WORKING to completion.
- Inserts periodic DRAM refresh strobes between transactions.
- Returns per-section completion status.

---
 rtl/hf_xfer_sched.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/hf_xfer_sched.sv
// hf_xfer_sched: shares the hyperfabric block mover and its MCU DRAM port among
// four section requesters.
//
// Round-robin arbitration picks one section. Its descriptor is latched onto the
// block-mover and MCU outputs, and REQ_ACK pulses for that section. The scheduler
// then runs the MCU align request/grant handshake, issues the mover start and
// follows BLCK_WORKING until the mover finishes. Between transactions it inserts
// a periodic DRAM refresh strobe.
//
// Registered outputs take their new value on the clock edge that enters a state.
// They are therefore visible while the FSM sits in that state: REQ_ACK during
// LOAD, DONE during DONE_ST.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   REQ/REQ_*                per-section request level and packed descriptors
//   REQ_ACK, DONE            one-hot single-cycle pulses per section
//   STAT_COUNT, STAT_ABORT   completion status, valid with DONE
//   BLCK_*                   block-mover command, issue pulse and status
//   MCU_*                    DRAM page, align request/grant, refresh strobe
//   RST_MVBLCK               mover direction select {rdmem, ~rdmem}
//   REFRESH_MISS             sticky: refresh demand arrived while one was pending
module hf_xfer_sched #(
    parameter int unsigned REFRESH_PERIOD = 390,
    parameter int unsigned REFRESH_HOLD   = 8,
    parameter int unsigned START_TIMEOUT  = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  REQ,
    input  logic [35:0] REQ_START,
    input  logic [23:0] REQ_COUNT,
    input  logic [91:0] REQ_PAGE,
    input  logic [3:0]  REQ_RDMEM,
    input  logic [3:0]  REQ_OPON,
    output logic [3:0]  REQ_ACK,
    output logic [3:0]  DONE,
    output logic [5:0]  STAT_COUNT,
    output logic        STAT_ABORT,
    output logic [8:0]  BLCK_START,
    output logic [5:0]  BLCK_COUNT_REQ,
    output logic [1:0]  BLCK_SECTION,
    output logic        BLCK_ISSUE,
    input  logic        BLCK_WORKING,
    input  logic [5:0]  BLCK_COUNT_SENT,
    input  logic        BLCK_ABRUPT_STOP,
    output logic [22:0] MCU_PAGE_ADDR,
    output logic [1:0]  MCU_REQUEST_ALIGN,
    input  logic [1:0]  MCU_GRANT_ALIGN,
    output logic [1:0]  RST_MVBLCK,
    output logic        MCU_REFRESH_STROBE,
    output logic        REFRESH_MISS
);

    localparam int unsigned RefW  = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam int unsigned HoldW = $clog2(REFRESH_HOLD + 1);
    localparam int unsigned TmoW  = $clog2(START_TIMEOUT + 1);

    localparam logic [2:0] StIdle      = 3'd0;
    localparam logic [2:0] StLoad      = 3'd1;
    localparam logic [2:0] StWaitGrant = 3'd2;
    localparam logic [2:0] StStart     = 3'd3;
    localparam logic [2:0] StRun       = 3'd4;
    localparam logic [2:0] StDone      = 3'd5;
    localparam logic [2:0] StRefresh   = 3'd6;

    logic [2:0]      state_q, state_d;
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic [1:0]      sect_q, sect_d;
    logic [RefW-1:0] ref_cnt_q, ref_cnt_d;
    logic            ref_pend_q, ref_pend_d;
    logic            miss_q, miss_d;
    logic            strobe_q, strobe_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            work_prev_q, work_prev_d;
    logic            abort_seen_q, abort_seen_d;
    logic [3:0]      ack_q, ack_d;
    logic [3:0]      done_q, done_d;
    logic [5:0]      stat_count_q, stat_count_d;
    logic            stat_abort_q, stat_abort_d;
    logic [8:0]      blk_start_q, blk_start_d;
    logic [5:0]      blk_count_q, blk_count_d;
    logic            issue_q, issue_d;
    logic [22:0]     page_q, page_d;
    logic [1:0]      req_align_q, req_align_d;
    logic [1:0]      mvblck_q, mvblck_d;

    // Unpacked per-section views of the packed descriptor buses.
    logic [8:0]  start_arr [4];
    logic [5:0]  count_arr [4];
    logic [22:0] page_arr  [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            start_arr[i] = REQ_START[9*i +: 9];
            count_arr[i] = REQ_COUNT[6*i +: 6];
            page_arr[i]  = REQ_PAGE[23*i +: 23];
        end
    end

    // The search runs from the highest offset down, so the last match kept is the
    // lowest offset from the pointer. That is the first set bit found when
    // searching upward from rr_ptr.
    logic       win_valid;
    logic [1:0] win_idx;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = rr_ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (REQ[rr_ptr_q + 2'(i)]) begin
                win_valid = 1'b1;
                win_idx   = rr_ptr_q + 2'(i);
            end
        end
    end

    logic ref_wrap;
    logic ref_take;

    assign ref_wrap = (ref_cnt_q == RefW'(REFRESH_PERIOD - 1));

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        sect_d       = sect_q;
        strobe_d     = strobe_q;
        hold_d       = hold_q;
        tmo_d        = tmo_q;
        abort_seen_d = abort_seen_q;
        ack_d        = 4'b0000;
        done_d       = 4'b0000;
        stat_count_d = stat_count_q;
        stat_abort_d = stat_abort_q;
        blk_start_d  = blk_start_q;
        blk_count_d  = blk_count_q;
        issue_d      = 1'b0;
        page_d       = page_q;
        req_align_d  = req_align_q;
        mvblck_d     = mvblck_q;
        ref_take     = 1'b0;
        work_prev_d  = BLCK_WORKING;

        unique case (state_q)
            StIdle: begin
                if (ref_pend_q) begin
                    state_d  = StRefresh;
                    strobe_d = ~strobe_q;
                    hold_d   = '0;
                    ref_take = 1'b1;
                end else if (win_valid) begin
                    state_d     = StLoad;
                    ack_d       = 4'b0001 << win_idx;
                    sect_d      = win_idx;
                    rr_ptr_d    = win_idx + 2'd1;
                    blk_start_d = start_arr[win_idx];
                    blk_count_d = count_arr[win_idx];
                    page_d      = page_arr[win_idx];
                    mvblck_d    = {REQ_RDMEM[win_idx], ~REQ_RDMEM[win_idx]};
                    // A zero-length transfer never touches the DRAM port.
                    req_align_d = (count_arr[win_idx] != 6'd0) ?
                                  {REQ_OPON[win_idx], ~REQ_OPON[win_idx]} : 2'b00;
                end
            end
            StLoad: begin
                abort_seen_d = 1'b0;
                if (blk_count_q == 6'd0) begin
                    state_d      = StDone;
                    done_d       = 4'b0001 << sect_q;
                    stat_count_d = 6'd0;
                    stat_abort_d = 1'b0;
                end else begin
                    state_d = StWaitGrant;
                end
            end
            StWaitGrant: begin
                if ((req_align_q & MCU_GRANT_ALIGN) != 2'b00) begin
                    state_d = StStart;
                    issue_d = 1'b1;
                    tmo_d   = '0;
                end
            end
            StStart: begin
                if (BLCK_WORKING) begin
                    state_d = StRun;
                end else if (tmo_q == TmoW'(START_TIMEOUT - 1)) begin
                    state_d      = StDone;
                    done_d       = 4'b0001 << sect_q;
                    stat_count_d = 6'd0;
                    stat_abort_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StRun: begin
                abort_seen_d = abort_seen_q | BLCK_ABRUPT_STOP;
                if (work_prev_q && !BLCK_WORKING) begin
                    state_d      = StDone;
                    done_d       = 4'b0001 << sect_q;
                    stat_count_d = BLCK_COUNT_SENT;
                    stat_abort_d = abort_seen_q | BLCK_ABRUPT_STOP;
                end
            end
            StDone: begin
                state_d     = StIdle;
                req_align_d = 2'b00;
                mvblck_d    = 2'b00;
            end
            StRefresh: begin
                if (hold_q == HoldW'(REFRESH_HOLD - 1)) begin
                    state_d = StIdle;
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // A wrap on the same cycle the pending demand is consumed is a fresh
        // demand, not a miss.
        ref_cnt_d  = ref_wrap ? '0 : ref_cnt_q + RefW'(1);
        ref_pend_d = ref_wrap | (ref_pend_q & ~ref_take);
        miss_d     = miss_q | (ref_wrap & ref_pend_q & ~ref_take);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            rr_ptr_q     <= 2'd0;
            sect_q       <= 2'd0;
            ref_cnt_q    <= '0;
            ref_pend_q   <= 1'b0;
            miss_q       <= 1'b0;
            strobe_q     <= 1'b0;
            hold_q       <= '0;
            tmo_q        <= '0;
            work_prev_q  <= 1'b0;
            abort_seen_q <= 1'b0;
            ack_q        <= 4'b0000;
            done_q       <= 4'b0000;
            stat_count_q <= 6'd0;
            stat_abort_q <= 1'b0;
            blk_start_q  <= 9'd0;
            blk_count_q  <= 6'd0;
            issue_q      <= 1'b0;
            page_q       <= 23'd0;
            req_align_q  <= 2'b00;
            mvblck_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            sect_q       <= sect_d;
            ref_cnt_q    <= ref_cnt_d;
            ref_pend_q   <= ref_pend_d;
            miss_q       <= miss_d;
            strobe_q     <= strobe_d;
            hold_q       <= hold_d;
            tmo_q        <= tmo_d;
            work_prev_q  <= work_prev_d;
            abort_seen_q <= abort_seen_d;
            ack_q        <= ack_d;
            done_q       <= done_d;
            stat_count_q <= stat_count_d;
            stat_abort_q <= stat_abort_d;
            blk_start_q  <= blk_start_d;
            blk_count_q  <= blk_count_d;
            issue_q      <= issue_d;
            page_q       <= page_d;
            req_align_q  <= req_align_d;
            mvblck_q     <= mvblck_d;
        end
    end

    assign REQ_ACK            = ack_q;
    assign DONE               = done_q;
    assign STAT_COUNT         = stat_count_q;
    assign STAT_ABORT         = stat_abort_q;
    assign BLCK_START         = blk_start_q;
    assign BLCK_COUNT_REQ     = blk_count_q;
    assign BLCK_SECTION       = sect_q;
    assign BLCK_ISSUE         = issue_q;
    assign MCU_PAGE_ADDR      = page_q;
    assign MCU_REQUEST_ALIGN  = req_align_q;
    assign RST_MVBLCK         = mvblck_q;
    assign MCU_REFRESH_STROBE = strobe_q;
    assign REFRESH_MISS       = miss_q;

endmodule
